// File: rtl/input_conditioner_if.sv
// Signal bundle between a raw-input source and the input conditioner.
// The source (master) drives raw_in/glitch_clr; the conditioner (slave) drives the clean outputs.
interface input_conditioner_if #(
    parameter int unsigned GLITCH_W = 8
);
    logic                raw_in;
    logic                glitch_clr;
    logic                x_db;
    logic                rise_pulse;
    logic                fall_pulse;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        output glitch_clr,
        input  x_db,
        input  rise_pulse,
        input  fall_pulse,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        input  glitch_clr,
        output x_db,
        output rise_pulse,
        output fall_pulse,
        output glitch_cnt
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces an asynchronous single-bit input, producing a clean level,
// one-cycle rise/fall strobes and a saturating count of rejected glitches.
module input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_LEVEL     = 1'b0,
    parameter int unsigned GLITCH_W        = 8
) (
    input logic                clk,
    input logic                clk_rst_n,
    input_conditioner_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLow,
        StPendHigh,
        StStableHigh,
        StPendLow
    } state_e;

    localparam state_e StReset = RESET_LEVEL ? StStableHigh : StStableLow;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   x_db_q, x_db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   glitch_hit;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_in};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_db_d     = x_db_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_hit = 1'b0;
        unique case (state_q)
            StStableLow: begin
                if (sync_out) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StStableHigh;
                        x_db_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = StPendHigh;
                        cnt_d   = CntOne;
                    end
                end
            end
            StPendHigh: begin
                if (!sync_out) begin
                    state_d    = StStableLow;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                    x_db_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStableHigh: begin
                if (!sync_out) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StStableLow;
                        x_db_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = StPendLow;
                        cnt_d   = CntOne;
                    end
                end
            end
            StPendLow: begin
                if (sync_out) begin
                    state_d    = StStableHigh;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                    x_db_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StReset;
        endcase
    end

    // Clear takes priority over a rejection landing on the same edge.
    always_comb begin
        glitch_d = glitch_q;
        if (bus.glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_hit && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            state_q  <= StReset;
            cnt_q    <= '0;
            x_db_q   <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_db_q   <= x_db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.x_db       = x_db_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: four instances cover default, long-debounce,
// high-reset-level and single-cycle-debounce configurations.
module tb_input_conditioner;

    logic clk;
    logic clk_rst_n;
    int   n_checks;
    int   n_errors;
    logic strobe0_seen;
    logic rise2_seen;
    logic lvl;

    input_conditioner_if #(.GLITCH_W(8)) bus0 ();
    input_conditioner_if #(.GLITCH_W(8)) bus1 ();
    input_conditioner_if #(.GLITCH_W(8)) bus2 ();
    input_conditioner_if #(.GLITCH_W(8)) bus3 ();

    input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_W(8)
    ) u_dut0 (.clk(clk), .clk_rst_n(clk_rst_n), .bus(bus0));

    input_conditioner #(
        .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1000), .RESET_LEVEL(1'b0), .GLITCH_W(8)
    ) u_dut1 (.clk(clk), .clk_rst_n(clk_rst_n), .bus(bus1));

    input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1), .GLITCH_W(8)
    ) u_dut2 (.clk(clk), .clk_rst_n(clk_rst_n), .bus(bus2));

    input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .GLITCH_W(8)
    ) u_dut3 (.clk(clk), .clk_rst_n(clk_rst_n), .bus(bus3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus0.rise_pulse || bus0.fall_pulse) strobe0_seen = 1'b1;
        if (bus2.rise_pulse) rise2_seen = 1'b1;
    endtask

    task automatic glitch0();
        bus0.raw_in = 1'b1;
        repeat (3) tick();
        bus0.raw_in = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        strobe0_seen = 1'b0;
        rise2_seen   = 1'b0;
        clk_rst_n    = 1'b0;
        bus0.raw_in = 1'b0; bus0.glitch_clr = 1'b0;
        bus1.raw_in = 1'b0; bus1.glitch_clr = 1'b0;
        bus2.raw_in = 1'b1; bus2.glitch_clr = 1'b0;
        bus3.raw_in = 1'b0; bus3.glitch_clr = 1'b0;

        repeat (3) tick();
        check_eq("rst_x_db", bus0.x_db, 0);
        check_eq("rst_rise", bus0.rise_pulse, 0);
        check_eq("rst_fall", bus0.fall_pulse, 0);
        check_eq("rst_glitch", bus0.glitch_cnt, 0);
        check_eq("rst_lvl1_x_db", bus2.x_db, 1);
        clk_rst_n  = 1'b1;
        rise2_seen = 1'b0;

        // Clean rise: x_db low through edge 5, high after edge 6
        repeat (3) tick();
        bus0.raw_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq($sformatf("rise_wait_e%0d", i), bus0.x_db, 0);
        end
        tick();
        check_eq("rise_x_db_e6", bus0.x_db, 1);
        check_eq("rise_pulse_e6", bus0.rise_pulse, 1);
        check_eq("rise_nofall_e6", bus0.fall_pulse, 0);
        tick();
        check_eq("rise_pulse_e7", bus0.rise_pulse, 0);
        check_eq("rise_x_db_e7", bus0.x_db, 1);
        check_eq("rise_glitch", bus0.glitch_cnt, 0);

        bus0.raw_in = 1'b0;
        repeat (8) tick();
        check_eq("fall_x_db", bus0.x_db, 0);

        // Short glitches and saturation
        strobe0_seen = 1'b0;
        glitch0();
        check_eq("glitch1_x_db", bus0.x_db, 0);
        check_eq("glitch1_cnt", bus0.glitch_cnt, 1);
        check_eq("glitch1_strobe", strobe0_seen, 0);
        repeat (299) glitch0();
        check_eq("glitch_sat_cnt", bus0.glitch_cnt, 255);
        check_eq("glitch_sat_x_db", bus0.x_db, 0);
        check_eq("glitch_sat_strobe", strobe0_seen, 0);

        bus0.glitch_clr = 1'b1;
        tick();
        bus0.glitch_clr = 1'b0;
        check_eq("clr_cnt", bus0.glitch_cnt, 0);
        repeat (5) glitch0();
        check_eq("five_glitches", bus0.glitch_cnt, 5);

        // Clear on the same edge the glitch is rejected (edge 6)
        bus0.raw_in = 1'b1;
        repeat (3) tick();
        bus0.raw_in = 1'b0;
        repeat (2) tick();
        check_eq("collide_pre", bus0.glitch_cnt, 5);
        bus0.glitch_clr = 1'b1;
        tick();
        bus0.glitch_clr = 1'b0;
        check_eq("collide_cnt", bus0.glitch_cnt, 0);
        repeat (5) tick();
        check_eq("collide_after", bus0.glitch_cnt, 0);

        // Asynchronous reset while PEND_HIGH with cnt=2
        glitch0();
        check_eq("pre_rst_glitch", bus0.glitch_cnt, 1);
        bus0.raw_in = 1'b1;
        repeat (4) tick();
        #2 clk_rst_n = 1'b0;
        #1;
        check_eq("midrst_x_db", bus0.x_db, 0);
        check_eq("midrst_rise", bus0.rise_pulse, 0);
        check_eq("midrst_fall", bus0.fall_pulse, 0);
        check_eq("midrst_glitch", bus0.glitch_cnt, 0);
        #1 clk_rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq($sformatf("postrst_wait_e%0d", i), bus0.x_db, 0);
        end
        tick();
        check_eq("postrst_x_db_e6", bus0.x_db, 1);
        check_eq("postrst_rise_e6", bus0.rise_pulse, 1);

        // Long debounce: fall lands on edge 1003
        bus1.raw_in = 1'b1;
        repeat (1010) tick();
        check_eq("long_pre_x_db", bus1.x_db, 1);
        bus1.raw_in = 1'b0;
        repeat (1002) tick();
        check_eq("long_x_db_e1002", bus1.x_db, 1);
        check_eq("long_fall_e1002", bus1.fall_pulse, 0);
        tick();
        check_eq("long_x_db_e1003", bus1.x_db, 0);
        check_eq("long_fall_e1003", bus1.fall_pulse, 1);
        check_eq("long_rise_e1003", bus1.rise_pulse, 0);
        tick();
        check_eq("long_fall_e1004", bus1.fall_pulse, 0);

        // Minimum debounce: 3-edge latency, one strobe per toggle
        for (int t = 0; t < 4; t++) begin
            lvl = (t % 2 == 0);
            bus3.raw_in = lvl;
            repeat (2) tick();
            check_eq($sformatf("min_t%0d_e2", t), bus3.x_db, !lvl);
            tick();
            check_eq($sformatf("min_t%0d_x_db", t), bus3.x_db, lvl);
            check_eq($sformatf("min_t%0d_rise", t), bus3.rise_pulse, lvl);
            check_eq($sformatf("min_t%0d_fall", t), bus3.fall_pulse, !lvl);
            tick();
            check_eq($sformatf("min_t%0d_quiet", t), bus3.rise_pulse | bus3.fall_pulse, 0);
        end
        check_eq("min_glitch", bus3.glitch_cnt, 0);

        // Reset level high with input held high
        check_eq("lvl1_x_db", bus2.x_db, 1);
        check_eq("lvl1_no_rise", rise2_seen, 0);
        check_eq("lvl1_glitch", bus2.glitch_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
